l1_wb_arbiter: RTL and testbench



---
 rtl/l1_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_l1_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_wb_arbiter.sv
// l1_wb_arbiter: shares one pipelined Wishbone master port between the L1I
// refill path and the L1D access path. Round-robin on ties, a single
// transaction in flight, a one-cycle completion pulse back to the winner and
// a grant-to-response watchdog that turns a silent slave into an error.
module l1_wb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // L1I refill requester (reads only)
  input  logic                  i_req_val,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_req_ack,
  output logic [DATA_WIDTH-1:0] i_ack_data,
  output logic                  i_ack_err,
  // L1D requester
  input  logic                  d_req_val,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic                  d_req_we,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  input  logic [BE_WIDTH-1:0]   d_req_be,
  output logic                  d_req_ack,
  output logic [DATA_WIDTH-1:0] d_ack_data,
  output logic                  d_ack_err,
  // Wishbone B4 pipelined master
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [BE_WIDTH-1:0]   wb_sel_o,
  output logic                  wb_tgc_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_stall_i,
  input  logic                  wb_err_i
);

  // Counter must be able to hold TIMEOUT; keep at least one bit when disabled.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]      CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [BE_WIDTH-1:0]   SEL_ZERO  = {BE_WIDTH{1'b0}};
  localparam logic [BE_WIDTH-1:0]   SEL_ALL   = {BE_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [BE_WIDTH-1:0]   sel_q, sel_d;
  logic                  tgc_q, tgc_d;
  // Owner of the current transaction: 1 = L1D, 0 = L1I.
  logic                  owner_is_d_q, owner_is_d_d;
  // Tie-break pointer: 1 = L1D wins the next tie. Reset 0 so I wins first.
  logic                  d_first_q, d_first_d;
  // Cycles elapsed since the grant cycle while the transaction is open.
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  i_ack_q, i_ack_d;
  logic [DATA_WIDTH-1:0] i_data_q, i_data_d;
  logic                  i_err_q, i_err_d;
  logic                  d_ack_q, d_ack_d;
  logic [DATA_WIDTH-1:0] d_data_q, d_data_d;
  logic                  d_err_q, d_err_d;

  logic                  pick_d_s;
  logic                  bus_done_s;
  logic                  timeout_s;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  fire_s;
  logic                  fire_err_s;
  logic [DATA_WIDTH-1:0] fire_data_s;

  assign bus_done_s = wb_ack_i | wb_err_i;
  // An error response, or any write, returns zero data.
  assign rd_data_s  = (wb_err_i || we_q) ? DATA_ZERO : wb_dat_i;
  assign timeout_s  = (TIMEOUT != 0) && (cnt_q == CNT_LIMIT);

  // Next-state, bus-side and response-side decode for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    tgc_d        = tgc_q;
    owner_is_d_d = owner_is_d_q;
    d_first_d    = d_first_q;
    cnt_d        = cnt_q;
    pick_d_s     = 1'b0;
    fire_s       = 1'b0;
    fire_err_s   = 1'b0;
    fire_data_s  = DATA_ZERO;

    case (state_q)
      ST_IDLE: begin
        if (i_req_val || d_req_val) begin
          // D wins when alone, or on a tie when the pointer favours it.
          pick_d_s     = d_req_val & (~i_req_val | d_first_q);
          owner_is_d_d = pick_d_s;
          d_first_d    = ~pick_d_s;
          cyc_d        = 1'b1;
          stb_d        = 1'b1;
          cnt_d        = CNT_ONE;
          state_d      = ST_REQ;
          if (pick_d_s) begin
            adr_d = d_req_addr;
            we_d  = d_req_we;
            dat_d = d_req_wdata;
            sel_d = d_req_be;
            tgc_d = 1'b0;
          end else begin
            adr_d = i_req_addr;
            we_d  = 1'b0;
            dat_d = DATA_ZERO;
            sel_d = SEL_ALL;
            tgc_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (!wb_stall_i) begin
          // Request accepted this cycle; a same-cycle response skips WAIT.
          stb_d = 1'b0;
          if (bus_done_s) begin
            fire_s      = 1'b1;
            fire_err_s  = wb_err_i;
            fire_data_s = rd_data_s;
          end else if (timeout_s) begin
            fire_s     = 1'b1;
            fire_err_s = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          // Still stalled: any ack/err seen now belongs to nothing of ours.
          if (timeout_s) begin
            fire_s     = 1'b1;
            fire_err_s = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ST_WAIT: begin
        if (bus_done_s) begin
          fire_s      = 1'b1;
          fire_err_s  = wb_err_i;
          fire_data_s = rd_data_s;
        end else if (timeout_s) begin
          fire_s     = 1'b1;
          fire_err_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase

    // Closing the transaction: release the bus and pulse the owner.
    state_d  = fire_s ? ST_RESP : state_d;
    cyc_d    = cyc_d & ~fire_s;
    stb_d    = stb_d & ~fire_s;
    i_ack_d  = fire_s & ~owner_is_d_q;
    i_err_d  = fire_s & ~owner_is_d_q & fire_err_s;
    i_data_d = (fire_s && !owner_is_d_q) ? fire_data_s : DATA_ZERO;
    d_ack_d  = fire_s & owner_is_d_q;
    d_err_d  = fire_s & owner_is_d_q & fire_err_s;
    d_data_d = (fire_s && owner_is_d_q) ? fire_data_s : DATA_ZERO;
  end

  // State, bus outputs, response outputs, watchdog and tie pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= ADDR_ZERO;
      dat_q        <= DATA_ZERO;
      sel_q        <= SEL_ZERO;
      tgc_q        <= 1'b0;
      owner_is_d_q <= 1'b0;
      d_first_q    <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
      i_ack_q      <= 1'b0;
      i_data_q     <= DATA_ZERO;
      i_err_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      d_data_q     <= DATA_ZERO;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      tgc_q        <= tgc_d;
      owner_is_d_q <= owner_is_d_d;
      d_first_q    <= d_first_d;
      cnt_q        <= cnt_d;
      i_ack_q      <= i_ack_d;
      i_data_q     <= i_data_d;
      i_err_q      <= i_err_d;
      d_ack_q      <= d_ack_d;
      d_data_q     <= d_data_d;
      d_err_q      <= d_err_d;
    end
  end

  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_sel_o   = sel_q;
  assign wb_tgc_o   = tgc_q;
  assign i_req_ack  = i_ack_q;
  assign i_ack_data = i_data_q;
  assign i_ack_err  = i_err_q;
  assign d_req_ack  = d_ack_q;
  assign d_ack_data = d_data_q;
  assign d_ack_err  = d_err_q;

endmodule

// File: tb/tb_l1_wb_arbiter.sv
// Bench for l1_wb_arbiter: directed steps followed by randomized traffic,
// checked against a transaction-level reference model (round-robin rule,
// response-cycle arithmetic from stall/wait/timeout, data/err rules).
module tb_l1_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 8;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req_val = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic          i_req_ack;
  logic [DW-1:0] i_ack_data;
  logic          i_ack_err;
  logic          d_req_val = 1'b0;
  logic [AW-1:0] d_req_addr = '0;
  logic          d_req_we = 1'b0;
  logic [DW-1:0] d_req_wdata = '0;
  logic [BW-1:0] d_req_be = '0;
  logic          d_req_ack;
  logic [DW-1:0] d_ack_data;
  logic          d_ack_err;
  logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_tgc_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [BW-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack_i = 1'b0;
  logic          wb_stall_i = 1'b0;
  logic          wb_err_i = 1'b0;

  int n_asserts = 0;
  int n_fail    = 0;
  // Reference model: which requester was granted most recently (1 = D).
  logic last_d = 1'b1;

  l1_wb_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_val(i_req_val), .i_req_addr(i_req_addr), .i_req_ack(i_req_ack),
    .i_ack_data(i_ack_data), .i_ack_err(i_ack_err),
    .d_req_val(d_req_val), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ack(d_req_ack),
    .d_ack_data(d_ack_data), .d_ack_err(d_ack_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_tgc_o(wb_tgc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_stall_i(wb_stall_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cyc"}, wb_cyc_o, 0);
    chk({tag, "_stb"}, wb_stb_o, 0);
    chk({tag, "_we"}, wb_we_o, 0);
    chk({tag, "_adr"}, wb_adr_o, 0);
    chk({tag, "_dat"}, wb_dat_o, 0);
    chk({tag, "_sel"}, wb_sel_o, 0);
    chk({tag, "_tgc"}, wb_tgc_o, 0);
    chk({tag, "_iack"}, {i_req_ack, i_ack_err, i_ack_data}, 0);
    chk({tag, "_dack"}, {d_req_ack, d_ack_err, d_ack_data}, 0);
  endtask

  // One transaction, entered at the falling edge of an IDLE cycle with the
  // request lines already set. The slave stalls s_cyc cycles, then answers
  // w_cyc cycles after accepting, with a response of the given kind.
  task automatic run_one(input int s_cyc, input int w_cyc, input int kind,
                         input logic [DW-1:0] rdata, output logic obs_tgc);
    logic          exp_d;
    logic [AW-1:0] e_adr;
    logic          e_we;
    logic [DW-1:0] e_dat;
    logic [BW-1:0] e_sel;
    logic          e_tgc;
    logic          e_err;
    logic [DW-1:0] e_data;
    int            k_cyc;
    int            r_cyc;
    bit            timed_out;

    exp_d  = d_req_val && (!i_req_val || !last_d);
    last_d = exp_d;
    if (exp_d) begin
      e_adr = d_req_addr; e_we = d_req_we; e_dat = d_req_wdata;
      e_sel = d_req_be;   e_tgc = 1'b0;
    end else begin
      e_adr = i_req_addr; e_we = 1'b0; e_dat = '0;
      e_sel = 4'hF;       e_tgc = 1'b1;
    end
    k_cyc     = (kind == K_NONE) ? 1000 : (s_cyc + 1 + w_cyc);
    timed_out = (k_cyc > TO);
    r_cyc     = timed_out ? (TO + 1) : (k_cyc + 1);
    e_err     = timed_out || (kind == K_ERR) || (kind == K_BOTH);
    e_data    = (e_err || e_we) ? '0 : rdata;
    obs_tgc   = 1'bx;

    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
    chk("idle_cyc", wb_cyc_o, 0);
    for (int n = 1; n < r_cyc; n++) begin
      @(negedge clk);
      if (n == 1) obs_tgc = wb_tgc_o;
      chk("open_cyc", wb_cyc_o, 1);
      chk("open_stb", wb_stb_o, (n <= s_cyc + 1) ? 1 : 0);
      chk("open_adr", wb_adr_o, e_adr);
      chk("open_we", wb_we_o, e_we);
      chk("open_sel", wb_sel_o, e_sel);
      chk("open_tgc", wb_tgc_o, e_tgc);
      if (exp_d) chk("open_dat", wb_dat_o, e_dat);
      chk("open_noack", {i_req_ack, d_req_ack}, 0);
      wb_dat_i = $urandom;
      if (n <= s_cyc) begin
        wb_stall_i = 1'b1;
        wb_ack_i   = 1'($urandom_range(0, 1));
        wb_err_i   = 1'($urandom_range(0, 1));
      end else if (n == k_cyc) begin
        wb_stall_i = 1'b0;
        wb_ack_i   = (kind == K_ACK) || (kind == K_BOTH);
        wb_err_i   = (kind == K_ERR) || (kind == K_BOTH);
        wb_dat_i   = rdata;
      end else begin
        wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
      end
    end
    @(negedge clk);
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    chk("resp_cyc", wb_cyc_o, 0);
    chk("resp_stb", wb_stb_o, 0);
    if (exp_d) begin
      chk("resp_dack", d_req_ack, 1);
      chk("resp_iack", i_req_ack, 0);
      chk("resp_ddata", d_ack_data, e_data);
      chk("resp_derr", d_ack_err, e_err);
      d_req_val = 1'b0;
    end else begin
      chk("resp_iack", i_req_ack, 1);
      chk("resp_dack", d_req_ack, 0);
      chk("resp_idata", i_ack_data, e_data);
      chk("resp_ierr", i_ack_err, e_err);
      i_req_val = 1'b0;
    end
    @(negedge clk);
    chk("post_acks", {i_req_ack, d_req_ack}, 0);
    chk("post_cyc", wb_cyc_o, 0);
  endtask

  initial begin
    logic tgc;
    int   r;
    int   kind;

    // Reset values.
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single I read at 0x100, slave acks two cycles after the strobe.
    i_req_addr = 32'h0000_0100; i_req_val = 1'b1;
    run_one(0, 2, K_ACK, 32'hDEAD_BEEF, tgc);
    chk("iread_tgc", tgc, 1);

    // D write with a three-cycle stall.
    d_req_addr = 32'h0000_0200; d_req_we = 1'b1; d_req_wdata = 32'h1234_5678;
    d_req_be = 4'h3; d_req_val = 1'b1;
    run_one(3, 0, K_ACK, 32'hCAFE_F00D, tgc);
    chk("dwrite_tgc", tgc, 0);

    // Both requesting continuously: grants alternate I, D, I, D.
    i_req_addr = 32'h0000_1000; d_req_addr = 32'h0000_2000; d_req_we = 1'b0;
    d_req_be = 4'hF; i_req_val = 1'b1; d_req_val = 1'b1;
    for (int t = 0; t < 4; t++) begin
      run_one(1, 1, K_ACK, $urandom, tgc);
      chk("alt_tgc", tgc, (t % 2 == 0) ? 1 : 0);
      i_req_val = 1'b1; d_req_val = 1'b1;
    end
    i_req_val = 1'b0; d_req_val = 1'b0;
    @(negedge clk);

    // Bus error in WAIT on a D read.
    d_req_addr = 32'h0000_0300; d_req_we = 1'b0; d_req_val = 1'b1;
    run_one(0, 2, K_ERR, 32'h5555_AAAA, tgc);

    // Silent slave: watchdog closes the transaction.
    i_req_addr = 32'h0000_0400; i_req_val = 1'b1;
    run_one(0, 0, K_NONE, 32'h0BAD_0BAD, tgc);

    // Reset while in WAIT.
    i_req_addr = 32'h0000_0500; i_req_val = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("wait_cyc", wb_cyc_o, 1);
    chk("wait_stb", wb_stb_o, 0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    i_req_val = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst_hold");
    rst_n = 1'b1; last_d = 1'b1;
    i_req_addr = 32'h0000_0600; d_req_addr = 32'h0000_0700; d_req_we = 1'b1;
    i_req_val = 1'b1; d_req_val = 1'b1;
    run_one(0, 0, K_ACK, $urandom, tgc);
    chk("postrst_first_i", tgc, 1);
    run_one(0, 1, K_ACK, $urandom, tgc);
    chk("postrst_then_d", tgc, 0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      if (!i_req_val && $urandom_range(0, 1) == 1) begin
        i_req_addr = $urandom; i_req_val = 1'b1;
      end
      if (!d_req_val && $urandom_range(0, 1) == 1) begin
        d_req_addr = $urandom; d_req_we = 1'($urandom_range(0, 1));
        d_req_wdata = $urandom; d_req_be = 4'($urandom_range(0, 15));
        d_req_val = 1'b1;
      end
      if (!i_req_val && !d_req_val) begin
        @(negedge clk);
        chk("rand_idle_cyc", wb_cyc_o, 0);
      end else begin
        r = $urandom_range(0, 9);
        kind = (r < 6) ? K_ACK : (r < 8) ? K_ERR : (r < 9) ? K_BOTH : K_NONE;
        run_one($urandom_range(0, 3), $urandom_range(0, 6), kind, $urandom, tgc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
